// File: rtl/sprite_overlay.sv
// Overlays one ROM-held sprite onto a VGA pixel stream. Position is latched at vblank start. Latency is 3 clocks.
// No backpressure: one pixel per clock, always accepted. Optional SPRITE_MIRROR_EN adds the horizontal flip input "mirror".
module sprite_overlay #(
    parameter int          SPR_W     = 48,
    parameter int          SPR_H     = 48,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
`ifdef SPRITE_MIRROR_EN
    input  logic        mirror,
`endif
    output logic [11:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0] SPR_W12 = 12'(SPR_W);
    localparam logic [11:0] SPR_H12 = 12'(SPR_H);
    localparam logic [5:0]  COL_MAX = 6'(SPR_W - 1);

    logic        vblnk_d;
    logic [10:0] xq;
    logic [10:0] yq;
    logic        mirror_q;
    logic        vblnk_rise;

    assign vblnk_rise = vblnk_in && !vblnk_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_d  <= 1'b0;
            xq       <= '0;
            yq       <= '0;
            mirror_q <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
            if (vblnk_rise) begin
                xq <= xpos;
                yq <= ypos;
`ifdef SPRITE_MIRROR_EN
                mirror_q <= mirror;
`else
                mirror_q <= 1'b0;
`endif
            end
        end
    end

    // 12-bit bounds so a sprite near x=2047 cannot wrap into low columns.
    logic [11:0] x_end;
    logic [11:0] y_end;
    logic        in_rect;
    logic [5:0]  col_raw;
    logic [5:0]  col;
    logic [5:0]  row;

    assign x_end   = {1'b0, xq} + SPR_W12;
    assign y_end   = {1'b0, yq} + SPR_H12;
    assign in_rect = ({1'b0, hcount_in} >= {1'b0, xq}) && ({1'b0, hcount_in} < x_end) &&
                     ({1'b0, vcount_in} >= {1'b0, yq}) && ({1'b0, vcount_in} < y_end);
    assign col_raw = hcount_in[5:0] - xq[5:0];
    assign row     = vcount_in[5:0] - yq[5:0];
    assign col     = mirror_q ? (COL_MAX - col_raw) : col_raw;

    logic [10:0] hcount_s1, vcount_s1, hcount_s2, vcount_s2;
    logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1, in_rect_s1;
    logic        hsync_s2, vsync_s2, hblnk_s2, vblnk_s2, in_rect_s2;
    logic [11:0] rgb_s1, rgb_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_addr <= '0;
            hcount_s1  <= '0;
            vcount_s1  <= '0;
            hsync_s1   <= 1'b0;
            vsync_s1   <= 1'b0;
            hblnk_s1   <= 1'b0;
            vblnk_s1   <= 1'b0;
            rgb_s1     <= '0;
            in_rect_s1 <= 1'b0;
        end else begin
            pixel_addr <= in_rect ? {row, col} : 12'h000;
            hcount_s1  <= hcount_in;
            vcount_s1  <= vcount_in;
            hsync_s1   <= hsync_in;
            vsync_s1   <= vsync_in;
            hblnk_s1   <= hblnk_in;
            vblnk_s1   <= vblnk_in;
            rgb_s1     <= rgb_in;
            in_rect_s1 <= in_rect;
        end
    end

    // Stage 2 waits out the ROM's one-clock read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_s2  <= '0;
            vcount_s2  <= '0;
            hsync_s2   <= 1'b0;
            vsync_s2   <= 1'b0;
            hblnk_s2   <= 1'b0;
            vblnk_s2   <= 1'b0;
            rgb_s2     <= '0;
            in_rect_s2 <= 1'b0;
        end else begin
            hcount_s2  <= hcount_s1;
            vcount_s2  <= vcount_s1;
            hsync_s2   <= hsync_s1;
            vsync_s2   <= vsync_s1;
            hblnk_s2   <= hblnk_s1;
            vblnk_s2   <= vblnk_s1;
            rgb_s2     <= rgb_s1;
            in_rect_s2 <= in_rect_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s2;
            vcount_out <= vcount_s2;
            hsync_out  <= hsync_s2;
            vsync_out  <= vsync_s2;
            hblnk_out  <= hblnk_s2;
            vblnk_out  <= vblnk_s2;
            if (hblnk_s2 || vblnk_s2)
                rgb_out <= 12'h000;
            else if (in_rect_s2 && (rgb_pixel != KEY_COLOR))
                rgb_out <= rgb_pixel;
            else
                rgb_out <= rgb_s2;
        end
    end

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: vector table plus hand sequences for reset, latch timing and mirroring.
module tb_sprite_overlay;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [11:0] pixel_addr, rgb_pixel, rgb_out;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
`ifdef SPRITE_MIRROR_EN
    logic        mirror = 1'b0;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sprite_overlay dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
`ifdef SPRITE_MIRROR_EN
        .mirror(mirror),
`endif
        .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // ROM model: one-clock read latency, key colour stored only at {row 0, col 5}.
    always @(posedge clk or negedge rst) begin
        if (!rst) rgb_pixel <= 12'h000;
        else      rgb_pixel <= (pixel_addr == 12'd5) ? 12'h0F0 : 12'hF00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [10:0] hc, input logic [10:0] vc,
                         input logic hb, input logic vb, input logic [11:0] bg);
        hcount_in = hc;
        vcount_in = vc;
        hsync_in  = hc[0];
        vsync_in  = vc[0];
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = bg;
    endtask

    // Hold one pixel for three clocks, then compare the pipeline outputs.
    task automatic apply(input string name, input logic [10:0] hc, input logic [10:0] vc,
                         input logic hb, input logic vb, input logic [11:0] bg,
                         input logic [11:0] exp_rgb, input logic [11:0] exp_addr);
        @(negedge clk);
        drive(hc, vc, hb, vb, bg);
        repeat (3) @(posedge clk);
        #1;
        check({name, ".rgb"},    {20'd0, rgb_out},    {20'd0, exp_rgb});
        check({name, ".addr"},   {20'd0, pixel_addr}, {20'd0, exp_addr});
        check({name, ".timing"}, {8'd0, hcount_out, vcount_out, hsync_out, vsync_out},
                                 {8'd0, hc, vc, hc[0], vc[0]});
        check({name, ".blank"},  {30'd0, hblnk_out, vblnk_out}, {30'd0, hb, vb});
    endtask

    task automatic latch_pos(input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        drive(11'd0, 11'd0, 1'b1, 1'b0, 12'h000);
        xpos = x;
        ypos = y;
        @(negedge clk);
        vblnk_in = 1'b1;
        @(negedge clk);
        vblnk_in = 1'b0;
    endtask

    typedef struct {
        logic [10:0] xp, yp, hc, vc;
        logic        hb, vb;
        logic [11:0] bg, exp_rgb, exp_addr;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [10:0] xp, input logic [10:0] yp,
                                input logic [10:0] hc, input logic [10:0] vc,
                                input logic hb, input logic vb,
                                input logic [11:0] er, input logic [11:0] ea);
        vec_t v;
        v.xp = xp; v.yp = yp; v.hc = hc; v.vc = vc; v.hb = hb; v.vb = vb;
        v.bg = 12'h00F; v.exp_rgb = er; v.exp_addr = ea;
        return v;
    endfunction

    logic [10:0] cur_x, cur_y;

    initial begin
        vecs[0]  = mk(100, 50,   99,  50, 0, 0, 12'h00F, 12'd0);
        vecs[1]  = mk(100, 50,  100,  50, 0, 0, 12'hF00, 12'd0);
        vecs[2]  = mk(100, 50,  105,  50, 0, 0, 12'h00F, 12'd5);
        vecs[3]  = mk(100, 50,  147,  97, 0, 0, 12'hF00, 12'd3055);
        vecs[4]  = mk(100, 50,  148,  97, 0, 0, 12'h00F, 12'd0);
        vecs[5]  = mk(100, 50,  120,  98, 0, 0, 12'h00F, 12'd0);
        vecs[6]  = mk(100, 50,  120,  49, 0, 0, 12'h00F, 12'd0);
        vecs[7]  = mk(100, 50,  130,  70, 0, 0, 12'hF00, 12'd1310);
        vecs[8]  = mk(100, 50,  110,  60, 1, 0, 12'h000, 12'd650);
        vecs[9]  = mk(100, 50,  110,  60, 0, 1, 12'h000, 12'd650);
        vecs[10] = mk(620, 460, 620, 460, 0, 0, 12'hF00, 12'd0);
        vecs[11] = mk(620, 460, 639, 479, 0, 0, 12'hF00, 12'd1235);
        vecs[12] = mk(620, 460, 619, 460, 0, 0, 12'h00F, 12'd0);
        vecs[13] = mk(620, 460, 630, 470, 1, 0, 12'h000, 12'd650);
        vecs[14] = mk(2040, 0,    0,   0, 0, 0, 12'h00F, 12'd0);
        vecs[15] = mk(2040, 0,    3,   0, 0, 0, 12'h00F, 12'd0);
        vecs[16] = mk(2040, 0,    7,   0, 0, 0, 12'h00F, 12'd0);
        vecs[17] = mk(2040, 0, 2047,   0, 0, 0, 12'hF00, 12'd7);
        vecs[18] = mk(2040, 0, 2039,   0, 0, 0, 12'h00F, 12'd0);
        vecs[19] = mk(2040, 0, 2040,   1, 0, 0, 12'hF00, 12'd64);

        // Reset, then a non-sprite pixel held while the pipeline refills.
        drive(11'd500, 11'd300, 1'b0, 1'b0, 12'hABC);
        #12;
        check("rst.async", {20'd0, rgb_out, hcount_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst.hold%0d", i),
                  {rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, 1'b0},
                  32'd0);
            check($sformatf("rst.addr%0d", i), {20'd0, pixel_addr}, 32'd0);
        end
        @(posedge clk); #1;
        check("rst.fill", {20'd0, rgb_out}, 32'h0ABC);
        check("rst.fill.hc", {21'd0, hcount_out}, 32'd500);

        cur_x = 11'h7FF;
        cur_y = 11'h7FF;
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].xp != cur_x || vecs[i].yp != cur_y) begin
                latch_pos(vecs[i].xp, vecs[i].yp);
                cur_x = vecs[i].xp;
                cur_y = vecs[i].yp;
            end
            apply($sformatf("vec%0d", i), vecs[i].hc, vecs[i].vc, vecs[i].hb, vecs[i].vb,
                  vecs[i].bg, vecs[i].exp_rgb, vecs[i].exp_addr);
        end

        // Mid-frame position change must wait for the next vblank edge.
        latch_pos(100, 50);
        apply("mid.before", 11'd110, 11'd60, 0, 0, 12'h00F, 12'hF00, 12'd650);
        xpos = 11'd300;
        apply("mid.old_pos", 11'd110, 11'd60, 0, 0, 12'h00F, 12'hF00, 12'd650);
        apply("mid.new_miss", 11'd300, 11'd60, 0, 0, 12'h00F, 12'h00F, 12'd0);
        latch_pos(300, 50);
        apply("mid.new_hit", 11'd300, 11'd60, 0, 0, 12'h00F, 12'hF00, 12'd640);
        apply("mid.old_miss", 11'd110, 11'd60, 0, 0, 12'h00F, 12'h00F, 12'd0);

`ifdef SPRITE_MIRROR_EN
        mirror = 1'b1;
        latch_pos(100, 50);
        mirror = 1'b0;
        apply("mir.left", 11'd100, 11'd50, 0, 0, 12'h00F, 12'hF00, 12'd47);
        apply("mir.right", 11'd147, 11'd50, 0, 0, 12'h00F, 12'hF00, 12'd0);
        apply("mir.key", 11'd142, 11'd50, 0, 0, 12'h00F, 12'h00F, 12'd5);
`endif

        // Reset mid-frame clears outputs at once and returns the sprite to (0,0).
        latch_pos(100, 50);
        apply("mrst.pre", 11'd130, 11'd70, 0, 0, 12'h00F, 12'hF00, 12'd1310);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("mrst.rgb", {20'd0, rgb_out}, 32'd0);
        check("mrst.hc", {21'd0, hcount_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        apply("mrst.xq0", 11'd130, 11'd70, 0, 0, 12'h00F, 12'h00F, 12'd0);
        apply("mrst.origin", 11'd10, 11'd20, 0, 0, 12'h00F, 12'hF00, 12'd1290);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
